word_arb_sched: RTL and testbench

Round-robin packet scheduler that shares one registered word-mux datapath among `WORDS_IN` requesters. It takes requests from `WORDS_IN` valid/ready streams and grants one requester at a time for a whole packet, delimited by `last`. It drives the mux select and enable and presents the selected word through a registered valid/ready output. It sits between multiple word producers and a single downstream consumer.

---
 rtl/word_arb_pkg.sv | 24 ++
 rtl/rr_picker.sv | 22 ++
 rtl/word_arb_sched.sv | 111 +++++++++++
 tb/tb_word_arb_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_arb_pkg.sv
// rtl/word_arb_pkg.sv - shared types and round-robin search for the word arbiter
package word_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int RR_MAX   = 64;
    localparam int RR_IDX_W = 6;

    // Returns the first set index of req searching upward from ptr+1 (mod n), or -1.
    function automatic int rr_pick(input logic [RR_MAX-1:0] req, input int ptr, input int n);
        int idx;
        idx = -1;
        for (int i = n; i >= 1; i--) begin
            if (req[RR_IDX_W'((ptr + i) % n)]) begin
                idx = (ptr + i) % n;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin search over the requesters
module rr_picker
    import word_arb_pkg::*;
#(
    parameter int SEL_NUM  = 2,
    parameter int WORDS_IN = 1 << SEL_NUM
) (
    input  logic [WORDS_IN-1:0] req,
    input  logic [SEL_NUM-1:0]  ptr,
    output logic [SEL_NUM-1:0]  idx,
    output logic                found
);

    int pick;

    always_comb begin
        pick  = rr_pick(RR_MAX'(req), int'(ptr), WORDS_IN);
        found = (pick >= 0);
        idx   = SEL_NUM'(pick);
    end

endmodule

// File: rtl/word_arb_sched.sv
// rtl/word_arb_sched.sv - packet-granular round-robin scheduler over a registered word mux
module word_arb_sched
    import word_arb_pkg::*;
#(
    parameter int DWIDTH   = 32,
    parameter int SEL_NUM  = 2,
    parameter int WORDS_IN = 1 << SEL_NUM
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WORDS_IN-1:0]        req_mask,
    input  logic [WORDS_IN-1:0]        in_valid,
    input  logic [WORDS_IN-1:0]        in_last,
    output logic [WORDS_IN-1:0]        in_ready,
    input  logic [DWIDTH*WORDS_IN-1:0] din,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DWIDTH-1:0]          out_data,
    output logic                       out_last,
    output logic [SEL_NUM-1:0]         out_sel,
    output logic                       busy
);

    arb_state_t          state_q, state_d;
    logic [SEL_NUM-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SEL_NUM-1:0]  out_sel_q, out_sel_d;
    logic                out_valid_q, out_last_q;
    logic [DWIDTH-1:0]   out_data_q;

    logic [WORDS_IN-1:0] eligible;
    logic [SEL_NUM-1:0]  pick_idx;
    logic                pick_found;
    logic                can_accept;
    logic                xfer;
    logic [DWIDTH-1:0]   words [WORDS_IN];

    for (genvar j = 0; j < WORDS_IN; j++) begin : g_words
        assign words[j] = din[j*DWIDTH +: DWIDTH];
    end

    assign eligible = in_valid & req_mask;

    rr_picker #(
        .SEL_NUM (SEL_NUM),
        .WORDS_IN(WORDS_IN)
    ) u_picker (
        .req  (eligible),
        .ptr  (rr_ptr_q),
        .idx  (pick_idx),
        .found(pick_found)
    );

    // Output register can take a word when empty or being drained this cycle.
    assign can_accept = !out_valid_q || out_ready;
    assign xfer       = (state_q == LOCK) && can_accept && in_valid[out_sel_q];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        out_sel_d = out_sel_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    out_sel_d = pick_idx;
                    rr_ptr_d  = pick_idx;
                    state_d   = LOCK;
                end
            end
            LOCK: begin
                if (xfer && in_last[out_sel_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= SEL_NUM'(WORDS_IN - 1);
            out_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            out_sel_q <= out_sel_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= words[out_sel_q];
            out_last_q  <= in_last[out_sel_q];
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign in_ready  = (state_q == LOCK && can_accept) ? (WORDS_IN'(1) << out_sel_q) : '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;
    assign busy      = (state_q == LOCK);

endmodule

// File: tb/tb_word_arb_sched.sv
// tb/tb_word_arb_sched.sv - self-checking bench for word_arb_sched
module tb_word_arb_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_mask = 4'hF;
    logic [3:0]   in_valid = '0;
    logic [3:0]   in_last = '0;
    logic [3:0]   in_ready;
    logic [127:0] din = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  out_data;
    logic         out_last;
    logic [1:0]   out_sel;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] qd[4][$];
    bit          ql[4][$];
    int          ex_sel[$];
    logic [31:0] ex_d[$];
    bit          ex_l[$];
    int          acc_sel[$];
    logic [31:0] acc_d[$];
    logic [31:0] obs_d[$];
    bit          obs_l[$];
    logic [3:0]  tr_ir[$];
    logic        tr_busy[$];
    logic [1:0]  tr_sel[$];
    logic [31:0] tr_od[$];

    word_arb_sched dut (
        .clk      (clk),
        .rst      (rst),
        .req_mask (req_mask),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .din      (din),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .out_sel  (out_sel),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    task automatic do_reset;
        rst = 1'b1;
        in_valid = '0;
        in_last = '0;
        din = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_queues;
        for (int j = 0; j < 4; j++) begin
            qd[j].delete();
            ql[j].delete();
        end
    endtask

    task automatic add_packet(input int j, input int len);
        for (int w = 0; w < len; w++) begin
            qd[j].push_back($urandom);
            ql[j].push_back(w == len - 1);
        end
    endtask

    // Packet-level reference: whole packets leave in round-robin order over
    // requesters that still have packets and are enabled by the mask.
    task automatic build_expected(input logic [3:0] mask);
        logic [31:0] cd[4][$];
        bit          cl[4][$];
        int          ptr;
        int          g;
        bit          l;
        ex_sel.delete(); ex_d.delete(); ex_l.delete();
        for (int j = 0; j < 4; j++) begin
            cd[j] = qd[j];
            cl[j] = ql[j];
        end
        ptr = 3;
        forever begin
            g = -1;
            for (int k = 1; k <= 4; k++) begin
                if (g < 0 && mask[(ptr + k) % 4] && cd[(ptr + k) % 4].size() > 0) g = (ptr + k) % 4;
            end
            if (g < 0) break;
            forever begin
                l = cl[g].pop_front();
                ex_sel.push_back(g);
                ex_d.push_back(cd[g].pop_front());
                ex_l.push_back(l);
                if (l) break;
            end
            ptr = g;
        end
    endtask

    task automatic run_traffic(input int max_cyc, input bit rnd_rdy, input int bp_start,
                               input bit rnd_stall, input int st_start, input int chg_after,
                               input logic [3:0] chg_mask, output bit timed_out);
        int cyc;
        int r3cnt;
        bit done;
        bit xfer;
        bit stall;
        bit mid[4];
        cyc = 0; r3cnt = 0; done = 1'b0;
        for (int j = 0; j < 4; j++) mid[j] = 1'b0;
        acc_sel.delete(); acc_d.delete(); obs_d.delete(); obs_l.delete();
        tr_ir.delete(); tr_busy.delete(); tr_sel.delete(); tr_od.delete();
        while (!done && cyc < max_cyc) begin
            @(posedge clk); #1;
            for (int j = 0; j < 4; j++) begin
                stall = mid[j] && ((rnd_stall && ($urandom % 3 == 0)) ||
                                   (st_start >= 0 && cyc >= st_start && cyc < st_start + 2));
                in_valid[j] = (qd[j].size() > 0) && !stall;
                din[j*32 +: 32] = (qd[j].size() > 0) ? qd[j][0] : 32'h0;
                in_last[j] = (qd[j].size() > 0) ? ql[j][0] : 1'b0;
            end
            out_ready = rnd_rdy ? ($urandom % 4 != 0)
                                : !(bp_start >= 0 && cyc >= bp_start && cyc < bp_start + 3);
            @(negedge clk);
            tr_ir.push_back(in_ready); tr_busy.push_back(busy);
            tr_sel.push_back(out_sel); tr_od.push_back(out_data);
            xfer = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (in_valid[j] && in_ready[j]) begin
                    xfer = 1'b1;
                    acc_sel.push_back(j);
                    acc_d.push_back(qd[j].pop_front());
                    mid[j] = !ql[j].pop_front();
                    if (j == 3) begin
                        r3cnt++;
                        if (r3cnt == chg_after) req_mask = chg_mask;
                    end
                end
            end
            if (out_valid && out_ready) begin
                obs_d.push_back(out_data);
                obs_l.push_back(out_last);
            end
            done = !xfer && !(out_valid && !out_ready);
            for (int j = 0; j < 4; j++) begin
                if (mid[j] || (req_mask[j] && qd[j].size() > 0)) done = 1'b0;
            end
            cyc++;
        end
        timed_out = !done;
        @(posedge clk); #1;
        in_valid = '0; in_last = '0; out_ready = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        n_cmp++; if (out_sel !== 2'd0) begin n_err++; $display("FAIL reset_out_sel: got %0d want 0", out_sel); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (in_ready !== 4'h0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    endtask

    task automatic test_single;
        logic [31:0] a0, a1, a2;
        a0 = $urandom; a1 = $urandom; a2 = $urandom;
        do_reset;
        req_mask = 4'hF;
        @(posedge clk); #1; in_valid = 4'b0100; din[95:64] = a0; in_last = 4'b0000;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || in_ready !== 4'h0) begin n_err++; $display("FAIL single_n: got busy %b in_ready %b want 0 0000", busy, in_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (out_sel !== 2'd2 || busy !== 1'b1) begin n_err++; $display("FAIL single_grant: got sel %0d busy %b want 2 1", out_sel, busy); end
        n_cmp++; if (in_ready !== 4'b0100 || out_valid !== 1'b0) begin n_err++; $display("FAIL single_ready: got in_ready %b out_valid %b want 0100 0", in_ready, out_valid); end
        @(posedge clk); #1; din[95:64] = a1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== a0 || out_last !== 1'b0) begin n_err++; $display("FAIL single_w0: got %b %h %b want 1 %h 0", out_valid, out_data, out_last, a0); end
        @(posedge clk); #1; din[95:64] = a2; in_last = 4'b0100;
        @(negedge clk);
        n_cmp++; if (out_data !== a1 || out_last !== 1'b0) begin n_err++; $display("FAIL single_w1: got %h %b want %h 0", out_data, out_last, a1); end
        @(posedge clk); #1; in_valid = 4'b0000; in_last = 4'b0000;
        @(negedge clk);
        n_cmp++; if (out_data !== a2 || out_last !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL single_w2: got %b %h %b want 1 %h 1", out_valid, out_data, out_last, a2); end
        n_cmp++; if (busy !== 1'b0 || in_ready !== 4'h0) begin n_err++; $display("FAIL single_idle: got busy %b in_ready %b want 0 0000", busy, in_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_round_robin;
        int g;
        do_reset;
        req_mask = 4'hF; in_valid = 4'hF; in_last = 4'hF;
        for (int j = 0; j < 4; j++) din[j*32 +: 32] = 32'hB0 + j;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            g = (c / 2) % 4;
            n_cmp++; if (busy !== (c % 2 == 0)) begin n_err++; $display("FAIL rr_busy[%0d]: got %b want %b", c, busy, c % 2 == 0); end
            if (c % 2 == 0) begin
                n_cmp++; if (out_sel !== 2'(g) || in_ready !== (4'b0001 << g)) begin n_err++; $display("FAIL rr_grant[%0d]: got sel %0d in_ready %b want %0d %b", c, out_sel, in_ready, g, 4'b0001 << g); end
            end else begin
                n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hB0 + g) begin n_err++; $display("FAIL rr_data[%0d]: got %b %h want 1 %h", c, out_valid, out_data, 32'hB0 + g); end
            end
        end
        @(posedge clk); #1; in_valid = '0; in_last = '0;
    endtask

    task automatic test_backpressure;
        bit to;
        do_reset;
        clear_queues;
        add_packet(0, 6);
        build_expected(4'hF);
        run_traffic(200, 1'b0, 4, 1'b0, -1, -1, 4'hF, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL bp_timeout: got not drained want drained"); end
        n_cmp++; if (acc_sel.size() != ex_sel.size() || obs_d.size() != ex_d.size()) begin n_err++; $display("FAIL bp_count: got in %0d out %0d want %0d", acc_sel.size(), obs_d.size(), ex_sel.size()); end
        for (int i = 0; i < ex_sel.size() && i < acc_sel.size() && i < obs_d.size(); i++) begin
            n_cmp++;
            if (acc_sel[i] != ex_sel[i] || acc_d[i] !== ex_d[i] || obs_d[i] !== ex_d[i] || obs_l[i] !== ex_l[i]) begin
                n_err++; $display("FAIL bp_word[%0d]: got sel %0d in %h out %h last %b want %0d %h %b", i, acc_sel[i], acc_d[i], obs_d[i], obs_l[i], ex_sel[i], ex_d[i], ex_l[i]);
            end
        end
        n_cmp++; if (tr_od.size() < 7) begin n_err++; $display("FAIL bp_trace: got %0d cycles want >= 7", tr_od.size()); end
        for (int c = 4; c < 7 && c < tr_od.size(); c++) begin
            n_cmp++; if (tr_ir[c] !== 4'h0 || tr_od[c] !== ex_d[2]) begin n_err++; $display("FAIL bp_hold[%0d]: got in_ready %b data %h want 0000 %h", c, tr_ir[c], tr_od[c], ex_d[2]); end
        end
    endtask

    task automatic test_mask;
        bit to;
        do_reset;
        clear_queues;
        for (int j = 0; j < 4; j++) for (int p = 0; p < 3; p++) add_packet(j, 3);
        req_mask = 4'b1010;
        build_expected(4'b1010);
        run_traffic(400, 1'b0, -1, 1'b0, -1, 4, 4'b0010, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL mask_timeout: got not drained want drained"); end
        n_cmp++; if (acc_sel.size() != 15 || obs_d.size() != 15) begin n_err++; $display("FAIL mask_count: got in %0d out %0d want 15", acc_sel.size(), obs_d.size()); end
        for (int i = 0; i < 15 && i < acc_sel.size() && i < obs_d.size(); i++) begin
            n_cmp++;
            if (acc_sel[i] != ex_sel[i] || acc_d[i] !== ex_d[i] || obs_d[i] !== ex_d[i] || obs_l[i] !== ex_l[i]) begin
                n_err++; $display("FAIL mask_word[%0d]: got sel %0d in %h out %h last %b want %0d %h %b", i, acc_sel[i], acc_d[i], obs_d[i], obs_l[i], ex_sel[i], ex_d[i], ex_l[i]);
            end
        end
        req_mask = 4'hF;
    endtask

    task automatic test_source_stall;
        bit to;
        do_reset;
        clear_queues;
        add_packet(0, 4);
        add_packet(2, 2);
        build_expected(4'hF);
        run_traffic(200, 1'b0, -1, 1'b0, 3, -1, 4'hF, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL stall_timeout: got not drained want drained"); end
        n_cmp++; if (acc_sel.size() != ex_sel.size() || obs_d.size() != ex_d.size()) begin n_err++; $display("FAIL stall_count: got in %0d out %0d want %0d", acc_sel.size(), obs_d.size(), ex_sel.size()); end
        for (int i = 0; i < ex_sel.size() && i < acc_sel.size() && i < obs_d.size(); i++) begin
            n_cmp++;
            if (acc_sel[i] != ex_sel[i] || acc_d[i] !== ex_d[i] || obs_d[i] !== ex_d[i] || obs_l[i] !== ex_l[i]) begin
                n_err++; $display("FAIL stall_word[%0d]: got sel %0d in %h out %h last %b want %0d %h %b", i, acc_sel[i], acc_d[i], obs_d[i], obs_l[i], ex_sel[i], ex_d[i], ex_l[i]);
            end
        end
        for (int c = 3; c < 5 && c < tr_ir.size(); c++) begin
            n_cmp++; if (tr_busy[c] !== 1'b1 || tr_sel[c] !== 2'd0 || tr_ir[c] !== 4'b0001) begin n_err++; $display("FAIL stall_hold[%0d]: got busy %b sel %0d in_ready %b want 1 0 0001", c, tr_busy[c], tr_sel[c], tr_ir[c]); end
        end
    endtask

    task automatic test_reset_mid_packet;
        do_reset;
        req_mask = 4'hF;
        @(posedge clk); #1; in_valid = 4'b0010; din[63:32] = 32'hCAFE0000; in_last = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1; din[63:32] = 32'hCAFE0001;
        #2; rst = 1'b1; #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin n_err++; $display("FAIL rstmid_out: got %b %h %b want 0 0 0", out_valid, out_data, out_last); end
        n_cmp++; if (out_sel !== 2'd0 || busy !== 1'b0 || in_ready !== 4'h0) begin n_err++; $display("FAIL rstmid_ctl: got sel %0d busy %b in_ready %b want 0 0 0000", out_sel, busy, in_ready); end
        @(negedge clk); rst = 1'b0; in_valid = 4'hF; in_last = 4'hF;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (out_sel !== 2'd0 || busy !== 1'b1) begin n_err++; $display("FAIL rstmid_first: got sel %0d busy %b want 0 1", out_sel, busy); end
        @(posedge clk); #1; in_valid = '0; in_last = '0;
    endtask

    task automatic test_random;
        bit to;
        for (int r = 0; r < 3; r++) begin
            do_reset;
            clear_queues;
            req_mask = 4'hF;
            for (int j = 0; j < 4; j++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) add_packet(j, $urandom_range(1, 4));
            end
            build_expected(4'hF);
            run_traffic(2000, 1'b1, -1, 1'b1, -1, -1, 4'hF, to);
            n_cmp++; if (to) begin n_err++; $display("FAIL rand_timeout[%0d]: got not drained want drained", r); end
            n_cmp++; if (acc_sel.size() != ex_sel.size() || obs_d.size() != ex_d.size()) begin n_err++; $display("FAIL rand_count[%0d]: got in %0d out %0d want %0d", r, acc_sel.size(), obs_d.size(), ex_sel.size()); end
            for (int i = 0; i < ex_sel.size() && i < acc_sel.size() && i < obs_d.size(); i++) begin
                n_cmp++;
                if (acc_sel[i] != ex_sel[i] || acc_d[i] !== ex_d[i] || obs_d[i] !== ex_d[i] || obs_l[i] !== ex_l[i]) begin
                    n_err++; $display("FAIL rand_word[%0d.%0d]: got sel %0d in %h out %h last %b want %0d %h %b", r, i, acc_sel[i], acc_d[i], obs_d[i], obs_l[i], ex_sel[i], ex_d[i], ex_l[i]);
                end
            end
            for (int c = 0; c < tr_ir.size(); c++) begin
                n_cmp++; if ($countones(tr_ir[c]) > 1) begin n_err++; $display("FAIL rand_onehot[%0d.%0d]: got in_ready %b want at most one bit", r, c, tr_ir[c]); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_mask;
        test_source_stall;
        test_reset_mid_packet;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
